// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response bus between the control unit (master)
// and the data memory responder (slave).
interface data_memory_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              re;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;
   logic              overrun;
   modport master (output re, we, addr, wdata, input rdata, ready, busy, err, overrun);
   modport slave (input re, we, addr, wdata, output rdata, ready, busy, err, overrun);
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data store answering re/we strobes with
// programmable wait states, a one-cycle ready pulse and held registered read data.
module data_memory_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input logic                    clk,
   input logic                    reset,
   data_memory_responder_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [DATA_W-1:0] r_rdata;
   logic              r_ready;
   logic              r_err;
   logic              r_ovr;

   logic              w_req;
   logic              w_inrange;
   logic              w_legal;
   logic              w_bad;
   logic [1:0]        w_next;
   logic              w_enter_resp;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_we;
   logic [IDX_W-1:0]  w_idx;

   assign w_req     = bus.re ^ bus.we;
   assign w_inrange = int'(bus.addr) < DEPTH;
   assign w_legal   = w_req & w_inrange;
   assign w_bad     = (bus.re & bus.we) | (w_req & ~w_inrange);

   // With zero wait states the access happens on the accepting edge, so use live inputs.
   assign w_addr  = (r_state == S_IDLE) ? bus.addr : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
   assign w_we    = (r_state == S_IDLE) ? bus.we : r_we;
   assign w_idx   = w_addr[IDX_W-1:0];

   always_comb begin
      w_next = S_IDLE;
      if (r_state == S_IDLE && w_legal) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      else if (r_state == S_WAIT) w_next = (r_cnt == 4'd0) ? S_RESP : S_WAIT;
   end

   assign w_enter_resp = w_next == S_RESP;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT) ? r_cnt - 4'd1 : 4'(WAIT_CYCLES - 1);
         r_ready <= w_enter_resp;
         r_err   <= (r_state == S_IDLE) & w_bad;
         if (r_state != S_IDLE && (bus.re | bus.we)) r_ovr <= 1'b1;
         if (w_enter_resp && !w_we) r_rdata <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_legal) begin
         r_addr  <= bus.addr;
         r_wdata <= bus.wdata;
         r_we    <= bus.we;
      end
   end

   // Storage survives reset; a reset on the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && w_enter_resp && w_we) r_mem[w_idx] <= w_wdata;
   end

   assign bus.rdata   = r_rdata;
   assign bus.ready   = r_ready;
   assign bus.busy    = r_state != S_IDLE;
   assign bus.err     = r_err;
   assign bus.overrun = r_ovr;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: four responders (different wait/depth) share one stimulus;
// a transaction scoreboard predicts every ready/err pulse, its cycle and rdata.
module tb_data_memory_responder;
   localparam int INF = 1 << 30;

   typedef struct {
      int          inst;
      bit          is_err;
      int          cyc;
      logic [15:0] rdata;
   } item_t;

   typedef struct {
      logic        r;
      logic        w;
      logic [7:0]  a;
      logic [15:0] d;
      logic        exp_err;
      logic [15:0] exp_rd;
   } vec_t;

   function automatic int wait_of(input int g);
      return g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : 0;
   endfunction

   function automatic int depth_of(input int g);
      return g == 1 ? 128 : 256;
   endfunction

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  addr = 8'd0;
   logic [15:0] wdata = 16'd0;
   logic [3:0]  w_ready, w_err, w_busy, w_ovr;
   logic [15:0] w_rdata [4];

   for (genvar g = 0; g < 4; g++) begin : gi
      data_memory_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();
      assign bus.re    = re;
      assign bus.we    = we;
      assign bus.addr  = addr;
      assign bus.wdata = wdata;
      data_memory_responder #(
         .ADDR_W(8), .DATA_W(16), .DEPTH(depth_of(g)), .WAIT_CYCLES(wait_of(g))
      ) dut (
         .clk(clk),
         .reset(reset),
         .bus(bus)
      );
      assign w_ready[g] = bus.ready;
      assign w_err[g]   = bus.err;
      assign w_busy[g]  = bus.busy;
      assign w_ovr[g]   = bus.overrun;
      assign w_rdata[g] = bus.rdata;
   end

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail = 0;
   int n_ready0 = 0;
   int n_err0 = 0;
   bit mon_en = 1'b0;

   item_t       sb [$];
   int          acc_cyc [4];
   int          free_at [4];
   int          ovr_from [4];
   bit          acc_we [4];
   logic [7:0]  acc_addr [4];
   logic [15:0] old_mem [4];
   logic [15:0] cur_rd [4];
   logic [15:0] shadow [4][256];

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc=%0d: got %h, required %h", name, g, cyc, act, exp);
      end
   endtask

   // Transaction-level prediction: one instance, one cycle of stimulus.
   task automatic model(input int g, input int c, input logic r, input logic w,
                        input logic rs, input logic [7:0] a, input logic [15:0] d);
      if (rs) begin
         if (c > acc_cyc[g] && c <= acc_cyc[g] + wait_of(g)) begin
            if (acc_we[g]) shadow[g][acc_addr[g]] = old_mem[g];
            for (int i = sb.size() - 1; i >= 0; i--)
               if (sb[i].inst == g) begin
                  sb.delete(i);
                  break;
               end
         end
         cur_rd[g] = 16'd0;
         free_at[g] = c + 1;
         ovr_from[g] = INF;
      end else if (r | w) begin
         if (c > acc_cyc[g] && c < free_at[g]) begin
            if (ovr_from[g] > c + 1) ovr_from[g] = c + 1;
         end else if ((r & w) || int'(a) >= depth_of(g)) begin
            sb.push_back('{g, 1'b1, c + 1, cur_rd[g]});
         end else begin
            acc_cyc[g] = c;
            acc_we[g] = w;
            acc_addr[g] = a;
            old_mem[g] = shadow[g][a];
            if (w) shadow[g][a] = d;
            else cur_rd[g] = shadow[g][a];
            sb.push_back('{g, 1'b0, c + 1 + wait_of(g), cur_rd[g]});
            free_at[g] = c + 2 + wait_of(g);
         end
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [7:0] a,
                       input logic [15:0] d, input logic rs);
      re = r;
      we = w;
      addr = a;
      wdata = d;
      reset = rs;
      for (int g = 0; g < 4; g++) model(g, cyc, r, w, rs, a, d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int g = 0; g < 4; g++) begin
            if (w_ready[g] === 1'b1 || w_err[g] === 1'b1) begin
               int idx;
               idx = -1;
               if (g == 0 && w_ready[g] === 1'b1) n_ready0++;
               if (g == 0 && w_err[g] === 1'b1) n_err0++;
               for (int i = 0; i < sb.size(); i++)
                  if (idx < 0 && sb[i].inst == g) idx = i;
               if (idx < 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp inst%0d cyc=%0d: got ready=%b err=%b, required none",
                           g, cyc, w_ready[g], w_err[g]);
               end else begin
                  chk("resp_kind", g, {30'd0, w_ready[g], w_err[g]}, {30'd0, ~sb[idx].is_err, sb[idx].is_err});
                  chk("resp_cycle", g, cyc, sb[idx].cyc);
                  chk("resp_rdata", g, {16'd0, w_rdata[g]}, {16'd0, sb[idx].rdata});
                  sb.delete(idx);
               end
            end
            if (reset !== 1'b1) begin
               chk("busy", g, {31'd0, w_busy[g]}, {31'd0, cyc > acc_cyc[g] && cyc < free_at[g]});
               chk("overrun", g, {31'd0, w_ovr[g]}, {31'd0, cyc >= ovr_from[g]});
            end
         end
      end
   end

   vec_t vt [13];

   initial begin
      vt[0]  = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0000};
      vt[1]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF};
      vt[2]  = '{1'b0, 1'b1, 8'h05, 16'h5555, 1'b0, 16'hBEEF};
      vt[3]  = '{1'b1, 1'b1, 8'h05, 16'hAAAA, 1'b1, 16'hBEEF};
      vt[4]  = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h5555};
      vt[5]  = '{1'b0, 1'b1, 8'hC0, 16'h00C0, 1'b0, 16'h5555};
      vt[6]  = '{1'b1, 1'b0, 8'hC0, 16'h0000, 1'b0, 16'h00C0};
      vt[7]  = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 1'b0, 16'h00C0};
      vt[8]  = '{1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'hFFFF};
      vt[9]  = '{1'b0, 1'b1, 8'h00, 16'h1357, 1'b0, 16'hFFFF};
      vt[10] = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h1357};
      vt[11] = '{1'b0, 1'b1, 8'h20, 16'h1111, 1'b0, 16'h1357};
      vt[12] = '{1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 16'h1111};
      for (int g = 0; g < 4; g++) begin
         acc_cyc[g] = -100;
         free_at[g] = 0;
         ovr_from[g] = INF;
         cur_rd[g] = 16'd0;
      end
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
      step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
      mon_en = 1'b1;
      for (int g = 0; g < 4; g++) begin
         chk("reset_rdata", g, {16'd0, w_rdata[g]}, 32'd0);
         chk("reset_flags", g, {28'd0, w_ready[g], w_busy[g], w_err[g], w_ovr[g]}, 32'd0);
      end
      for (int i = 0; i < 13; i++) begin
         int r0, e0;
         r0 = n_ready0;
         e0 = n_err0;
         step(vt[i].r, vt[i].w, vt[i].a, vt[i].d, 1'b0);
         idle(6);
         chk($sformatf("vec%0d_err", i), 0, n_err0 - e0, {31'd0, vt[i].exp_err});
         chk($sformatf("vec%0d_ready", i), 0, n_ready0 - r0, {31'd0, ~vt[i].exp_err});
         chk($sformatf("vec%0d_rdata", i), 0, {16'd0, w_rdata[0]}, {16'd0, vt[i].exp_rd});
      end
      for (int g = 0; g < 4; g++) chk("no_overrun_yet", g, {31'd0, w_ovr[g]}, 32'd0);
      // re held for three cycles: one access per busy instance, overrun becomes sticky
      begin
         int r0;
         r0 = n_ready0;
         for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h10, 16'd0, 1'b0);
         idle(6);
         chk("held_re_one_access", 0, n_ready0 - r0, 32'd1);
      end
      chk("held_re_rdata", 1, {16'd0, w_rdata[1]}, 32'h0000_BEEF);
      chk("overrun_sticky", 1, {31'd0, w_ovr[1]}, 32'd1);
      step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
      idle(1);
      for (int g = 0; g < 4; g++) chk("overrun_cleared", g, {31'd0, w_ovr[g]}, 32'd0);
      // reset while the write is still waiting aborts it, except with zero wait states
      step(1'b0, 1'b1, 8'h20, 16'h1234, 1'b0);
      step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1);
      chk("busy_after_reset", 2, {31'd0, w_busy[2]}, 32'd0);
      idle(2);
      step(1'b1, 1'b0, 8'h20, 16'd0, 1'b0);
      idle(6);
      chk("aborted_write_old", 2, {16'd0, w_rdata[2]}, 32'h0000_1111);
      chk("aborted_write_old", 0, {16'd0, w_rdata[0]}, 32'h0000_1111);
      chk("zero_wait_write_done", 3, {16'd0, w_rdata[3]}, 32'h0000_1234);
      idle(10);
      while (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL missing_resp inst%0d: got nothing, required %s by cyc=%0d",
                  sb[0].inst, sb[0].is_err ? "err" : "ready", sb[0].cyc);
         sb.delete(0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the multicycle 16-bit RISC datapath.
- Answers the read-enable/write-enable strobes issued by the processor control FSM: captures address and write data, inserts programmable wait states, then performs the access and returns a one-cycle ready pulse.
- Read data is registered and held.
- Holds the word-addressed instruction/data store.

Parameters:
ADDR_W, 8, address width in words
DATA_W, 16, data word width
DEPTH, 256, number of implemented words (legal addresses 0..DEPTH-1), DEPTH <= 2^ADDR_W
WAIT_CYCLES, 1, wait states between acceptance and response (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
re  input  1  read request strobe from control unit
we  input  1  write request strobe from control unit
addr  input  ADDR_W  word address, sampled at acceptance
wdata  input  DATA_W  write data, sampled at acceptance
rdata  output  DATA_W  registered read data, held until next completed read
ready  output  1  one-cycle pulse: access complete
busy  output  1  high while a request is in flight (WAIT or RESP)
err  output  1  one-cycle pulse: illegal request rejected
overrun  output  1  sticky: request strobe seen while busy

Behaviour:
- Reset (reset=1 at rising edge):
  - state=IDLE; rdata=0, ready=0, busy=0, err=0, overrun=0; wait counter=0.
  - Memory array contents unaffected.
  - Reset mid-operation aborts the request: no memory write occurs, no ready pulse.
- States:
  - IDLE: busy=0. On an edge with re^we=1, latch addr/wdata/op and go to:
    - WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0;
    - RESP otherwise.
  - WAIT: busy=1. Counter decrements each cycle; at 0 go to RESP.
  - RESP: busy=1, ready=1 for exactly one cycle, then IDLE.
- Access point: on the edge entering RESP.
  - Write: mem[addr_q] <= wdata_q.
  - Read: rdata <= mem[addr_q].
  - rdata is therefore valid in the ready cycle and held afterwards.
  - Writes leave rdata unchanged.
- Latency: request sampled at the edge ending cycle k produces ready in cycle k+1+WAIT_CYCLES. Back-to-back throughput: one request per WAIT_CYCLES+2 cycles.
- Illegal requests, sampled in IDLE:
  - re=1 and we=1 together, or addr_q >= DEPTH: no access, err=1 in cycle k+1, no ready pulse, state stays IDLE, busy stays 0.
  - rdata unchanged.
- Strobes in WAIT or RESP: ignored (no second access), overrun set to 1 and held until reset. This includes strobes held high across multiple cycles.
- Level re held high continuously in IDLE after RESP: treated as a new request on the first IDLE cycle. The control unit must deassert between accesses.
- ready and err are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then WAIT_CYCLES=1, we=1 addr=0x10 wdata=0xBEEF for one cycle -> busy=1 next 2 cycles, ready pulse in cycle k+2, rdata stays 0x0000, err=0.
2. After 1, re=1 addr=0x10 -> ready in cycle k+2 with rdata=0xBEEF; rdata still 0xBEEF 5 cycles later with re=0.
3. re=1 and we=1 addr=0x05 -> err=1 in cycle k+1, ready never asserted, busy stays 0, subsequent read of 0x05 returns prior contents.
4. DEPTH=128, re=1 addr=0xC0 -> err pulse, no ready; overrun=0.
5. re held high 3 cycles from IDLE with WAIT_CYCLES=2 -> exactly one access completes, ready in cycle k+3, overrun=1 and stays 1 until reset=1 clears it to 0.
6. WAIT_CYCLES=3, write 0x1234 to 0x20, reset asserted during WAIT -> ready never pulses, busy=0 after reset edge, read of 0x20 returns old value (not 0x1234). WAIT_CYCLES=0 read -> ready in cycle k+1.
